// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Hazard / sequencing controller for a 5-stage RV32I pipeline.
// Every cycle it decides which pipeline registers hold, which ones load a
// NOP, and whether MEM/WB takes a bubble.
//
// Hazard sources, in RUN priority order:
//   data-memory freeze, ECALL/EBREAK halt, EX redirect, load-use.
// A data-memory wait is bounded by TIMEOUT. When the wait expires, the
// pipeline is released and a sticky bus_err flag is raised.
//
// Ports
//   clk, reset                     clock (rising edge); async active-high reset
//   id_valid, id_rs1/2, id_use_*   instruction currently in ID
//   ex_mem_read, ex_rd             load in EX and its destination register
//   ex_redirect, ex_halt           taken branch/jump; ECALL/EBREAK, both in EX
//   mem_req, mem_ready             MEM-stage data access and its completion
//   *_hold                         stage register keeps its value
//   if_id_flush, id_ex_flush       stage register loads a NOP
//   mem_wb_bubble                  MEM/WB register loads a NOP
//   halted, bus_err                core stopped; sticky memory-timeout flag
//   stall_cnt, flush_cnt           cycles with pc_hold=1; redirect events
//
// Handshake: mem_req is a level. A request with mem_ready low freezes the
// pipeline. The access completes in the first cycle that mem_ready is high,
// or it is forced to complete after TIMEOUT frozen cycles.
//
// The FSM state is held in state_q (type state_e).

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int DRAIN   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic        ex_halt,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_bubble,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [31:0]     flush_cnt_q, flush_cnt_d;

  logic            freeze;
  logic            lu;
  logic            resolve;      // cycle evaluates halt/redirect/load-use
  logic            timeout_rel;  // release forced by an expired memory wait
  logic            redirect_evt;

  assign freeze = mem_req & ~mem_ready;

  assign lu = id_valid & ex_mem_read & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) |
               (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    bus_err_d     = bus_err_q;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    resolve       = 1'b0;
    timeout_rel   = 1'b0;
    redirect_evt  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          state_d       = ST_MEM_WAIT;
          wait_cnt_d    = WW'(1);
        end else begin
          resolve = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          resolve = 1'b1;
          state_d = ST_RUN;
        end else if (wait_cnt_q == WW'(TIMEOUT)) begin
          // A forced release always returns to RUN, even if a halt is in EX.
          resolve     = 1'b1;
          timeout_rel = 1'b1;
          bus_err_d   = 1'b1;
          state_d     = ST_RUN;
        end else begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          wait_cnt_d    = wait_cnt_q + WW'(1);
        end
      end

      ST_DRAIN: begin
        // The front end stays empty. The older instructions in EX/MEM and
        // MEM/WB keep retiring.
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (freeze) begin
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
        end else if (drain_cnt_q == DW'(DRAIN - 1)) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end

      ST_HALTED: begin
        halted      = 1'b1;
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
      end

      default: state_d = ST_RUN;
    endcase

    // The RUN priority list, also used on a release cycle out of MEM_WAIT.
    if (resolve) begin
      if (ex_halt) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (!timeout_rel) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end else if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        redirect_evt = 1'b1;
      end else if (lu) begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end
    end

    stall_cnt_d = stall_cnt_q + {31'd0, pc_hold};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_evt};

    // While reset is high, the stage registers are cleared rather than held.
    if (reset) begin
      pc_hold       = 1'b0;
      if_id_hold    = 1'b0;
      id_ex_hold    = 1'b0;
      ex_mem_hold   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
      halted        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
